// File: rtl/stopwatch_display_scan.sv
// ============================================================================
// Module  : stopwatch_display_scan
// Purpose : Scans four BCD digits onto a common-anode 7-segment display.
//           Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros above DP_DIGIT.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module stopwatch_display_scan #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLINK_FRAMES = 64,
    parameter int DP_DIGIT     = 2
) (
    input  logic        clk,
    input  logic        RESET,
    input  logic [16:1] Q,
    input  logic        BLINK,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        frame_done
);

    localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PW-1:0] c_DIV_MAX   = PW'(REFRESH_DIV - 1);
    localparam logic [FW-1:0] c_FRAME_MAX = FW'(BLINK_FRAMES - 1);

    logic [PW-1:0] r_presc;
    logic [1:0]    r_idx;
    logic [15:0]   r_shadow;
    logic [FW-1:0] r_fcnt;
    logic          r_phase;

    logic          w_tick;
    logic          w_wrap;
    logic [1:0]    w_idx_next;
    logic [15:0]   w_src;
    logic [3:0]    w_digit;
    logic [6:0]    w_pattern;
    logic          w_phase_next;
    logic          w_lz_blank;
    logic          w_blank;

    assign w_tick     = (r_presc == c_DIV_MAX);
    assign w_idx_next = r_idx + 2'd1;
    assign w_wrap     = w_tick && (r_idx == 2'd3);

    // The wrap edge loads the shadow, so that slot must decode the live input.
    assign w_src   = w_wrap ? Q : r_shadow;
    assign w_digit = w_src[4*w_idx_next +: 4];

    // Phase value that will be in force for the frame beginning on this edge.
    assign w_phase_next = (w_wrap && (r_fcnt == c_FRAME_MAX)) ? ~r_phase : r_phase;

    always_comb begin
        w_pattern = 7'h40;
        case (w_digit)
            4'd0: w_pattern = 7'h3F;
            4'd1: w_pattern = 7'h06;
            4'd2: w_pattern = 7'h5B;
            4'd3: w_pattern = 7'h4F;
            4'd4: w_pattern = 7'h66;
            4'd5: w_pattern = 7'h6D;
            4'd6: w_pattern = 7'h7D;
            4'd7: w_pattern = 7'h07;
            4'd8: w_pattern = 7'h7F;
            4'd9: w_pattern = 7'h6F;
            default: w_pattern = 7'h40;
        endcase
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [3:0] w_zero_above;

    // w_zero_above[i]: digit i and every higher digit are zero.
    always_comb begin
        logic z;
        z = 1'b1;
        w_zero_above = 4'b0000;
        for (int i = 3; i >= 0; i--) begin
            z = z && (w_src[4*i +: 4] == 4'd0);
            w_zero_above[i] = z;
        end
    end

    assign w_lz_blank = (int'(w_idx_next) > DP_DIGIT) && w_zero_above[w_idx_next];
`else
    assign w_lz_blank = 1'b0;
`endif

    assign w_blank = (BLINK && w_phase_next) || w_lz_blank;

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            r_presc    <= '0;
            r_idx      <= 2'd3;
            r_shadow   <= 16'h0000;
            r_fcnt     <= '0;
            r_phase    <= 1'b0;
            an         <= 4'b1111;
            seg        <= 7'h7F;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= w_wrap;
            r_presc    <= w_tick ? '0 : r_presc + 1'b1;
            if (w_tick) begin
                r_idx <= w_idx_next;
                if (w_blank) begin
                    an  <= 4'b1111;
                    seg <= 7'h7F;
                    dp  <= 1'b1;
                end else begin
                    an  <= ~(4'b0001 << w_idx_next);
                    seg <= ~w_pattern;
                    dp  <= !(int'(w_idx_next) == DP_DIGIT);
                end
            end
            if (w_wrap) begin
                r_shadow <= Q;
                r_fcnt   <= (r_fcnt == c_FRAME_MAX) ? '0 : r_fcnt + 1'b1;
                r_phase  <= w_phase_next;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_display_scan.sv
// ============================================================================
// Module  : tb_stopwatch_display_scan
// Purpose : Directed, table-driven bench for stopwatch_display_scan (DIV=4, 2 blink frames, DP on digit 2).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stopwatch_display_scan;

    logic        clk;
    logic        RESET;
    logic [16:1] Q;
    logic        BLINK;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    int n_checks;
    int n_fail;

    stopwatch_display_scan #(
        .REFRESH_DIV (4),
        .BLINK_FRAMES(2),
        .DP_DIGIT    (2)
    ) dut (
        .clk       (clk),
        .RESET     (RESET),
        .Q         (Q),
        .BLINK     (BLINK),
        .seg       (seg),
        .dp        (dp),
        .an        (an),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] q;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        dp;
        logic        fd;
    } vec_t;

    vec_t vecs[24];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [3:0] e_an, input logic [6:0] e_seg,
                       input logic e_dp, input logic e_fd);
        n_checks++;
        if ({an, seg, dp, frame_done} !== {e_an, e_seg, e_dp, e_fd}) begin
            n_fail++;
            $display("FAIL %s: got an=%b seg=%h dp=%b fd=%b, want an=%b seg=%h dp=%b fd=%b",
                     name, an, seg, dp, frame_done, e_an, e_seg, e_dp, e_fd);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // frame 1: Q changes mid-frame, digits stay from the wrap snapshot
        vecs[0]  = '{16'h4059, 4'hE, 7'h10, 1'b1, 1'b1};
        vecs[1]  = '{16'h4059, 4'hD, 7'h12, 1'b1, 1'b0};
        vecs[2]  = '{16'h4100, 4'hB, 7'h40, 1'b0, 1'b0};
        vecs[3]  = '{16'h4100, 4'h7, 7'h19, 1'b1, 1'b0};
        vecs[4]  = '{16'h4100, 4'hE, 7'h40, 1'b1, 1'b1};
        vecs[5]  = '{16'h4100, 4'hD, 7'h40, 1'b1, 1'b0};
        vecs[6]  = '{16'h4100, 4'hB, 7'h79, 1'b0, 1'b0};
        vecs[7]  = '{16'h4100, 4'h7, 7'h19, 1'b1, 1'b0};
        vecs[8]  = '{16'h405B, 4'hE, 7'h3F, 1'b1, 1'b1};
        vecs[9]  = '{16'h405B, 4'hD, 7'h12, 1'b1, 1'b0};
        vecs[10] = '{16'h405B, 4'hB, 7'h40, 1'b0, 1'b0};
        vecs[11] = '{16'h405B, 4'h7, 7'h19, 1'b1, 1'b0};
        vecs[12] = '{16'h0105, 4'hE, 7'h12, 1'b1, 1'b1};
        vecs[13] = '{16'h0105, 4'hD, 7'h40, 1'b1, 1'b0};
        vecs[14] = '{16'h0105, 4'hB, 7'h79, 1'b0, 1'b0};
`ifdef LEADING_ZERO_BLANK_EN
        vecs[15] = '{16'h0105, 4'hF, 7'h7F, 1'b1, 1'b0};
`else
        vecs[15] = '{16'h0105, 4'h7, 7'h40, 1'b1, 1'b0};
`endif
        vecs[16] = '{16'h8762, 4'hE, 7'h24, 1'b1, 1'b1};
        vecs[17] = '{16'h8762, 4'hD, 7'h02, 1'b1, 1'b0};
        vecs[18] = '{16'h8762, 4'hB, 7'h78, 1'b0, 1'b0};
        vecs[19] = '{16'h8762, 4'h7, 7'h00, 1'b1, 1'b0};
        vecs[20] = '{16'hCF31, 4'hE, 7'h79, 1'b1, 1'b1};
        vecs[21] = '{16'hCF31, 4'hD, 7'h30, 1'b1, 1'b0};
        vecs[22] = '{16'hCF31, 4'hB, 7'h3F, 1'b0, 1'b0};
        vecs[23] = '{16'hCF31, 4'h7, 7'h3F, 1'b1, 1'b0};

        Q     = 16'h4059;
        BLINK = 1'b0;
        RESET = 1'b1;
        #2;
        chk("reset_state", 4'hF, 7'h7F, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1 RESET = 1'b0;

        for (int i = 0; i < 3; i++) begin
            step();
            chk("dark_before_first_tick", 4'hF, 7'h7F, 1'b1, 1'b0);
        end

        for (int k = 0; k < 24; k++) begin
            Q = vecs[k].q;
            if (k > 0) repeat (3) step();
            step();
            chk($sformatf("vec%0d", k), vecs[k].an, vecs[k].seg, vecs[k].dp, vecs[k].fd);
        end

        // blink: phase is 1 for frames 7 and 10-11, 0 for frames 8-9
        BLINK = 1'b1;
        for (int f = 7; f <= 10; f++) begin
            logic lit;
            lit = (f == 8) || (f == 9);
            step();
            repeat (3) step();
            if (lit) chk($sformatf("blink_f%0d_s0", f), 4'hE, 7'h79, 1'b1, 1'b1);
            else     chk($sformatf("blink_f%0d_s0", f), 4'hF, 7'h7F, 1'b1, 1'b1);
            repeat (4) step();
            repeat (4) step();
            if (lit) chk($sformatf("blink_f%0d_s2", f), 4'hB, 7'h3F, 1'b0, 1'b0);
            else     chk($sformatf("blink_f%0d_s2", f), 4'hF, 7'h7F, 1'b1, 1'b0);
            repeat (4) step();
        end

        // frame 11 is dark; BLINK drops after slot 1 and takes effect at slot 2
        repeat (4) step();
        chk("blink_f11_s0", 4'hF, 7'h7F, 1'b1, 1'b1);
        repeat (4) step();
        chk("blink_f11_s1", 4'hF, 7'h7F, 1'b1, 1'b0);
        BLINK = 1'b0;
        step();
        chk("blink_release_waits_tick", 4'hF, 7'h7F, 1'b1, 1'b0);
        repeat (3) step();
        chk("blink_release_at_tick", 4'hB, 7'h3F, 1'b0, 1'b0);

        // asynchronous reset in the middle of a slot
        step();
        #2 RESET = 1'b1;
        #1;
        chk("async_reset_immediate", 4'hF, 7'h7F, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1 RESET = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("dark_after_reset", 4'hF, 7'h7F, 1'b1, 1'b0);
        end
        step();
        chk("first_slot_after_reset", 4'hE, 7'h79, 1'b1, 1'b1);
        step();
        chk("frame_done_one_cycle", 4'hE, 7'h79, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
